// File: rtl/rob_ctrl_if.sv
// Handshake bundle between the ROB controller and the rename/dispatch, writeback, flush and commit paths.
// The master side drives dispatch, writeback and flush; the slave side (rob_ctrl) drives ready, index and commit.
interface rob_ctrl_if #(
    parameter int IDX_W  = 6,
    parameter int PREG_W = 7
);
    logic              disp_valid;
    logic              disp_ready;
    logic [IDX_W-1:0]  disp_robidx;
    logic              wb_valid;
    logic [IDX_W-1:0]  wb_robidx;
    logic              wb_skip;
    logic              flush_valid;
    logic              commit_valid;
    logic [4:0]        commit_lrd;
    logic [PREG_W-1:0] commit_prd;
    logic [PREG_W-1:0] commit_old_prd;
    logic              commit_need_to_wb;

    modport master (
        output disp_valid, wb_valid, wb_robidx, wb_skip, flush_valid,
        input  disp_ready, disp_robidx, commit_valid, commit_lrd, commit_prd,
               commit_old_prd, commit_need_to_wb
    );

    modport slave (
        input  disp_valid, wb_valid, wb_robidx, wb_skip, flush_valid,
        output disp_ready, disp_robidx, commit_valid, commit_lrd, commit_prd,
               commit_old_prd, commit_need_to_wb
    );
endinterface

// File: rtl/rob_ctrl.sv
// Reorder-buffer control: head/tail pointers with wrap bit, occupancy count, per-entry strobes
// and a registered single-instruction in-order commit stage.
module rob_ctrl #(
    parameter int DEPTH  = 64,
    parameter int IDX_W  = 6,
    parameter int PREG_W = 7
) (
    input  logic                    clock,
    input  logic                    reset_n,
    rob_ctrl_if.slave               bus,
    output logic [DEPTH-1:0]        ent_enq_valid,
    output logic [DEPTH-1:0]        ent_wb_set_complete,
    output logic                    ent_wb_set_skip,
    output logic [DEPTH-1:0]        ent_commit_vld,
    output logic                    ent_flush_vld,
    input  logic [DEPTH-1:0]        ent_ready_to_commit,
    input  logic [DEPTH*5-1:0]      ent_lrd_vec,
    input  logic [DEPTH*PREG_W-1:0] ent_prd_vec,
    input  logic [DEPTH*PREG_W-1:0] ent_old_prd_vec,
    input  logic [DEPTH-1:0]        ent_need_to_wb_vec,
    output logic                    rob_empty,
    output logic                    rob_full
);

    logic [IDX_W:0]    head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic              commit_valid_q, commit_valid_d;
    logic [4:0]        commit_lrd_q, commit_lrd_d;
    logic [PREG_W-1:0] commit_prd_q, commit_prd_d;
    logic [PREG_W-1:0] commit_old_prd_q, commit_old_prd_d;
    logic              commit_need_to_wb_q, commit_need_to_wb_d;

    logic [IDX_W-1:0]  head_idx, tail_idx;
    logic              enq_fire, commit_fire;

    logic [4:0]        lrd_arr     [DEPTH];
    logic [PREG_W-1:0] prd_arr     [DEPTH];
    logic [PREG_W-1:0] old_prd_arr [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_unpack
        assign lrd_arr[g]     = ent_lrd_vec[g*5 +: 5];
        assign prd_arr[g]     = ent_prd_vec[g*PREG_W +: PREG_W];
        assign old_prd_arr[g] = ent_old_prd_vec[g*PREG_W +: PREG_W];
    end

    assign head_idx  = head_q[IDX_W-1:0];
    assign tail_idx  = tail_q[IDX_W-1:0];
    assign rob_empty = (head_q == tail_q);
    assign rob_full  = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

    // Strobes are forced low while reset is held so entries never see a stray pulse.
    assign bus.disp_ready  = reset_n & ~rob_full & ~bus.flush_valid;
    assign bus.disp_robidx = tail_idx;
    assign enq_fire        = bus.disp_valid & bus.disp_ready;
    assign commit_fire     = reset_n & ent_ready_to_commit[head_idx] & ~rob_empty & ~bus.flush_valid;

    assign ent_enq_valid       = DEPTH'(enq_fire) << tail_idx;
    assign ent_commit_vld      = DEPTH'(commit_fire) << head_idx;
    assign ent_wb_set_complete = DEPTH'(bus.wb_valid & reset_n) << bus.wb_robidx;
    assign ent_wb_set_skip     = bus.wb_skip;
    assign ent_flush_vld       = bus.flush_valid;

    always_comb begin
        head_d              = head_q;
        tail_d              = tail_q;
        count_d             = count_q;
        commit_valid_d      = commit_fire;
        commit_lrd_d        = commit_lrd_q;
        commit_prd_d        = commit_prd_q;
        commit_old_prd_d    = commit_old_prd_q;
        commit_need_to_wb_d = commit_need_to_wb_q;
        if (commit_fire) begin
            head_d              = head_q + (IDX_W+1)'(1);
            commit_lrd_d        = lrd_arr[head_idx];
            commit_prd_d        = prd_arr[head_idx];
            commit_old_prd_d    = old_prd_arr[head_idx];
            commit_need_to_wb_d = ent_need_to_wb_vec[head_idx];
        end
        if (enq_fire) tail_d = tail_q + (IDX_W+1)'(1);
        if (enq_fire && !commit_fire)      count_d = count_q + (IDX_W+1)'(1);
        else if (commit_fire && !enq_fire) count_d = count_q - (IDX_W+1)'(1);
        // Flush squashes everything in flight; commit and enqueue are already blocked above.
        if (bus.flush_valid) begin
            head_d         = '0;
            tail_d         = '0;
            count_d        = '0;
            commit_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q              <= '0;
            tail_q              <= '0;
            count_q             <= '0;
            commit_valid_q      <= 1'b0;
            commit_lrd_q        <= '0;
            commit_prd_q        <= '0;
            commit_old_prd_q    <= '0;
            commit_need_to_wb_q <= 1'b0;
        end else begin
            head_q              <= head_d;
            tail_q              <= tail_d;
            count_q             <= count_d;
            commit_valid_q      <= commit_valid_d;
            commit_lrd_q        <= commit_lrd_d;
            commit_prd_q        <= commit_prd_d;
            commit_old_prd_q    <= commit_old_prd_d;
            commit_need_to_wb_q <= commit_need_to_wb_d;
        end
    end

    assign bus.commit_valid      = commit_valid_q;
    assign bus.commit_lrd        = commit_lrd_q;
    assign bus.commit_prd        = commit_prd_q;
    assign bus.commit_old_prd    = commit_old_prd_q;
    assign bus.commit_need_to_wb = commit_need_to_wb_q;

    a_occupancy: assert property (@(posedge clock) disable iff (!reset_n)
        (rob_empty == (count_q == '0)) && (rob_full == (count_q == (IDX_W+1)'(DEPTH))));

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl: dispatch, writeback, in-order commit, full/wrap, flush and async reset.
module tb_rob_ctrl;
    localparam int DEPTH  = 64;
    localparam int IDX_W  = 6;
    localparam int PREG_W = 7;

    logic                    clock;
    logic                    reset_n;
    logic [DEPTH-1:0]        ent_enq_valid, ent_wb_set_complete, ent_commit_vld;
    logic                    ent_wb_set_skip, ent_flush_vld;
    logic [DEPTH-1:0]        ent_ready_to_commit;
    logic [DEPTH*5-1:0]      ent_lrd_vec;
    logic [DEPTH*PREG_W-1:0] ent_prd_vec, ent_old_prd_vec;
    logic [DEPTH-1:0]        ent_need_to_wb_vec;
    logic                    rob_empty, rob_full;

    int n_checks = 0;
    int n_errors = 0;

    rob_ctrl_if #(.IDX_W(IDX_W), .PREG_W(PREG_W)) bus ();

    rob_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PREG_W(PREG_W)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .bus                 (bus),
        .ent_enq_valid       (ent_enq_valid),
        .ent_wb_set_complete (ent_wb_set_complete),
        .ent_wb_set_skip     (ent_wb_set_skip),
        .ent_commit_vld      (ent_commit_vld),
        .ent_flush_vld       (ent_flush_vld),
        .ent_ready_to_commit (ent_ready_to_commit),
        .ent_lrd_vec         (ent_lrd_vec),
        .ent_prd_vec         (ent_prd_vec),
        .ent_old_prd_vec     (ent_old_prd_vec),
        .ent_need_to_wb_vec  (ent_need_to_wb_vec),
        .rob_empty           (rob_empty),
        .rob_full            (rob_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [4:0] lrd_of(int i);
        return 5'(i * 7 + 3);
    endfunction
    function automatic logic [PREG_W-1:0] prd_of(int i);
        return PREG_W'(i + 40);
    endfunction
    function automatic logic [PREG_W-1:0] old_of(int i);
        return PREG_W'(i * 3 + 1);
    endfunction
    function automatic logic need_of(int i);
        return (i % 2) == 1;
    endfunction
    function automatic logic [63:0] oh(int i);
        logic [63:0] one;
        one = 64'd1;
        return one << i;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_commit(input string tag, input int idx);
        chk({tag, "_valid"},   64'(bus.commit_valid), 64'd1);
        chk({tag, "_lrd"},     64'(bus.commit_lrd), 64'(lrd_of(idx)));
        chk({tag, "_prd"},     64'(bus.commit_prd), 64'(prd_of(idx)));
        chk({tag, "_old_prd"}, 64'(bus.commit_old_prd), 64'(old_of(idx)));
        chk({tag, "_need_wb"}, 64'(bus.commit_need_to_wb), 64'(need_of(idx)));
    endtask

    task automatic idle_inputs();
        bus.disp_valid      = 1'b0;
        bus.wb_valid        = 1'b0;
        bus.wb_robidx       = '0;
        bus.wb_skip         = 1'b0;
        bus.flush_valid     = 1'b0;
        ent_ready_to_commit = '0;
    endtask

    task automatic enqueue_n(input int n);
        for (int k = 0; k < n; k++) begin
            bus.disp_valid = 1'b1;
            step();
        end
        bus.disp_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_lrd_vec[i*5 +: 5]                = lrd_of(i);
            ent_prd_vec[i*PREG_W +: PREG_W]      = prd_of(i);
            ent_old_prd_vec[i*PREG_W +: PREG_W]  = old_of(i);
            ent_need_to_wb_vec[i]                = need_of(i);
        end
        idle_inputs();
        reset_n = 1'b0;
        step();
        step();

        // Reset state, strobes held low even with dispatch/writeback offered
        bus.disp_valid = 1'b1;
        bus.wb_valid   = 1'b1;
        #1;
        chk("rst_empty", 64'(rob_empty), 64'd1);
        chk("rst_full", 64'(rob_full), 64'd0);
        chk("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
        chk("rst_commit_lrd", 64'(bus.commit_lrd), 64'd0);
        chk("rst_enq_strobe", 64'(ent_enq_valid), 64'd0);
        chk("rst_wb_strobe", 64'(ent_wb_set_complete), 64'd0);
        idle_inputs();
        reset_n = 1'b1;
        step();

        // Empty + enqueue: entry 0 claims ready but cannot commit yet
        ent_ready_to_commit = oh(0);
        bus.disp_valid = 1'b1;
        #1;
        chk("empty_no_commit", 64'(ent_commit_vld), 64'd0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("disp_idx%0d", k), 64'(bus.disp_robidx), 64'(k));
            chk($sformatf("enq_oh%0d", k), 64'(ent_enq_valid), oh(k));
            ent_ready_to_commit = '0;
            step();
        end
        bus.disp_valid = 1'b0;
        #1;
        chk("count3", 64'(dut.count_q), 64'd3);
        chk("not_empty", 64'(rob_empty), 64'd0);

        // Writeback idx1 (skip) then idx0; commits must come out 0 then 1
        bus.wb_valid = 1'b1; bus.wb_robidx = 6'd1; bus.wb_skip = 1'b1;
        #1;
        chk("wb1_strobe", 64'(ent_wb_set_complete), oh(1));
        chk("wb1_skip", 64'(ent_wb_set_skip), 64'd1);
        chk("wb1_no_commit", 64'(ent_commit_vld), 64'd0);
        step();
        bus.wb_robidx = 6'd0; bus.wb_skip = 1'b0;
        ent_ready_to_commit = 64'h2;
        #1;
        chk("wb0_strobe", 64'(ent_wb_set_complete), oh(0));
        chk("wb0_skip", 64'(ent_wb_set_skip), 64'd0);
        chk("head0_not_ready", 64'(ent_commit_vld), 64'd0);
        step();
        bus.wb_valid = 1'b0;
        ent_ready_to_commit = 64'h3;
        #1;
        chk("commit_oh0", 64'(ent_commit_vld), oh(0));
        chk("commit_valid_before", 64'(bus.commit_valid), 64'd0);
        step();
        ent_ready_to_commit = 64'h2;
        #1;
        chk_commit("c0", 0);
        chk("commit_oh1", 64'(ent_commit_vld), oh(1));
        step();
        ent_ready_to_commit = '0;
        #1;
        chk_commit("c1", 1);
        step();
        chk("commit_valid_drop", 64'(bus.commit_valid), 64'd0);
        chk("commit_lrd_hold", 64'(bus.commit_lrd), 64'(lrd_of(1)));
        chk("count1", 64'(dut.count_q), 64'd1);

        // head=2, tail=3: grow to 10 then enqueue+commit together
        enqueue_n(9);
        chk("count10", 64'(dut.count_q), 64'd10);
        bus.disp_valid = 1'b1;
        ent_ready_to_commit = oh(2);
        #1;
        chk("both_enq_oh", 64'(ent_enq_valid), oh(12));
        chk("both_commit_oh", 64'(ent_commit_vld), oh(2));
        step();
        bus.disp_valid = 1'b0;
        ent_ready_to_commit = oh(3);
        #1;
        chk("both_count", 64'(dut.count_q), 64'd10);
        chk("both_tail_adv", 64'(bus.disp_robidx), 64'd13);
        chk("both_head_adv", 64'(ent_commit_vld), oh(3));
        chk_commit("c2", 2);
        ent_ready_to_commit = '0;

        // Flush at count 20 with a ready head: flush wins over everything
        enqueue_n(10);
        chk("count20", 64'(dut.count_q), 64'd20);
        bus.flush_valid = 1'b1;
        bus.disp_valid  = 1'b1;
        bus.wb_valid    = 1'b1;
        bus.wb_robidx   = 6'd5;
        ent_ready_to_commit = oh(3);
        #1;
        chk("flush_no_commit", 64'(ent_commit_vld), 64'd0);
        chk("flush_no_ready", 64'(bus.disp_ready), 64'd0);
        chk("flush_no_enq", 64'(ent_enq_valid), 64'd0);
        chk("flush_bcast", 64'(ent_flush_vld), 64'd1);
        chk("flush_wb_passes", 64'(ent_wb_set_complete), oh(5));
        step();
        idle_inputs();
        #1;
        chk("flush_empty", 64'(rob_empty), 64'd1);
        chk("flush_count", 64'(dut.count_q), 64'd0);
        chk("flush_head", 64'(dut.head_q), 64'd0);
        chk("flush_tail", 64'(bus.disp_robidx), 64'd0);
        chk("flush_commit_valid", 64'(bus.commit_valid), 64'd0);

        // Fill to 64, then commit while dispatch is offered
        enqueue_n(64);
        chk("fill_full", 64'(rob_full), 64'd1);
        chk("fill_not_empty", 64'(rob_empty), 64'd0);
        chk("fill_count", 64'(dut.count_q), 64'd64);
        bus.disp_valid = 1'b1;
        ent_ready_to_commit = oh(0);
        #1;
        chk("full_no_ready", 64'(bus.disp_ready), 64'd0);
        chk("full_no_enq", 64'(ent_enq_valid), 64'd0);
        chk("full_commit_oh", 64'(ent_commit_vld), oh(0));
        step();
        ent_ready_to_commit = '0;
        #1;
        chk("after_commit_ready", 64'(bus.disp_ready), 64'd1);
        chk("wrap_enq_oh", 64'(ent_enq_valid), oh(0));
        chk("wrap_tail", 64'(dut.tail_q), 64'h40);
        chk_commit("cfull", 0);
        step();
        bus.disp_valid = 1'b0;
        #1;
        chk("refull", 64'(rob_full), 64'd1);
        chk("wrap_tail_next", 64'(dut.tail_q), 64'h41);

        // Async reset with count 5 and a commit pending
        bus.flush_valid = 1'b1;
        step();
        idle_inputs();
        enqueue_n(5);
        bus.disp_valid = 1'b1;
        ent_ready_to_commit = oh(0);
        step();
        bus.disp_valid = 1'b0;
        ent_ready_to_commit = oh(1);
        #1;
        chk("pre_rst_count", 64'(dut.count_q), 64'd5);
        chk("pre_rst_cv", 64'(bus.commit_valid), 64'd1);
        bus.disp_valid = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_commit_valid", 64'(bus.commit_valid), 64'd0);
        chk("arst_commit_prd", 64'(bus.commit_prd), 64'd0);
        chk("arst_empty", 64'(rob_empty), 64'd1);
        chk("arst_commit_oh", 64'(ent_commit_vld), 64'd0);
        chk("arst_enq_oh", 64'(ent_enq_valid), 64'd0);
        chk("arst_count", 64'(dut.count_q), 64'd0);
        step();
        reset_n = 1'b1;
        #1;
        chk("post_rst_idx", 64'(bus.disp_robidx), 64'd0);
        chk("post_rst_enq", 64'(ent_enq_valid), oh(0));
        step();
        idle_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
